// File: rtl/universal_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : universal_register                                         |
// | Description : WIDTH-bit register with hold/load/shift/rotate/count modes,|
// |               true and complement outputs, and a registered serial/carry |
// |               output. Define UNIVERSAL_REGISTER_PARITY_EN to add a       |
// |               registered Parity output.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module universal_register #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
`ifdef UNIVERSAL_REGISTER_PARITY_EN
  output logic             Parity,
`endif
  output logic             ShiftOut
);

  localparam logic [WIDTH-1:0] c_RESET_Q = RESET_VALUE[WIDTH-1:0];

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_SHL  = 3'b010;
  localparam logic [2:0] c_MODE_SHR  = 3'b011;
  localparam logic [2:0] c_MODE_ROL  = 3'b100;
  localparam logic [2:0] c_MODE_ROR  = 3'b101;
  localparam logic [2:0] c_MODE_INC  = 3'b110;
  localparam logic [2:0] c_MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_shiftOut;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextShiftOut;

  always_comb begin
    w_nextQ        = r_q;
    w_nextShiftOut = r_shiftOut;
    case (Mode)
      c_MODE_HOLD: begin
        w_nextQ        = r_q;
        w_nextShiftOut = r_shiftOut;
      end
      c_MODE_LOAD: begin
        w_nextQ        = D;
        w_nextShiftOut = 1'b0;
      end
      c_MODE_SHL: begin
        w_nextQ        = {r_q[WIDTH-2:0], SerIn};
        w_nextShiftOut = r_q[WIDTH-1];
      end
      c_MODE_SHR: begin
        w_nextQ        = {SerIn, r_q[WIDTH-1:1]};
        w_nextShiftOut = r_q[0];
      end
      c_MODE_ROL: begin
        w_nextQ        = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_nextShiftOut = r_q[WIDTH-1];
      end
      c_MODE_ROR: begin
        w_nextQ        = {r_q[0], r_q[WIDTH-1:1]};
        w_nextShiftOut = r_q[0];
      end
      // Carry/borrow flags the wrap-around edge only.
      c_MODE_INC: begin
        w_nextQ        = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        w_nextShiftOut = &r_q;
      end
      c_MODE_DEC: begin
        w_nextQ        = r_q - {{(WIDTH-1){1'b0}}, 1'b1};
        w_nextShiftOut = ~|r_q;
      end
      default: begin
        w_nextQ        = r_q;
        w_nextShiftOut = r_shiftOut;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q        <= c_RESET_Q;
      r_shiftOut <= 1'b0;
    end else if (En) begin
      r_q        <= w_nextQ;
      r_shiftOut <= w_nextShiftOut;
    end
  end

`ifdef UNIVERSAL_REGISTER_PARITY_EN
  // Parity is taken from the next-state value so it changes with Q.
  logic r_parity;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_parity <= ^c_RESET_Q;
    end else if (En) begin
      r_parity <= ^w_nextQ;
    end
  end

  assign Parity = r_parity;
`endif

  assign Q        = r_q;
  assign notQ     = ~r_q;
  assign ShiftOut = r_shiftOut;

endmodule
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// Scoreboard bench for universal_register (WIDTH=8, RESET_VALUE=0) with a
// behavioural model; a monitor compares every post-edge DUT state.
module tb_universal_register;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       SerIn;
  logic [7:0] Q;
  logic [7:0] notQ;
  logic       ShiftOut;
`ifdef UNIVERSAL_REGISTER_PARITY_EN
  logic       Parity;
`endif

  universal_register #(.WIDTH(8), .RESET_VALUE(32'd0)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .En       (En),
    .Mode     (Mode),
    .D        (D),
    .SerIn    (SerIn),
    .Q        (Q),
    .notQ     (notQ),
`ifdef UNIVERSAL_REGISTER_PARITY_EN
    .Parity   (Parity),
`endif
    .ShiftOut (ShiftOut)
  );

  typedef struct {
    int q;
    int so;
    int par;
  } exp_t;

  exp_t sbq[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   done       = 0;

  // Reference state kept as plain integers.
  int mq  = 0;
  int mso = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int oddOnes(input int v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += (v >> i) & 1;
    return c % 2;
  endfunction

  task automatic step(input bit rst, input bit en, input int mode,
                      input int d, input bit ser);
    exp_t e;
    @(negedge Clk);
    Rst   = rst;
    En    = en;
    Mode  = mode[2:0];
    D     = d[7:0];
    SerIn = ser;
    if (rst) begin
      mq  = 0;
      mso = 0;
    end else if (en) begin
      case (mode)
        0: ;
        1: begin mso = 0;               mq = d % 256; end
        2: begin mso = mq / 128;        mq = (mq * 2 + ser) % 256; end
        3: begin mso = mq % 2;          mq = mq / 2 + ser * 128; end
        4: begin mso = mq / 128;        mq = (mq * 2 + mq / 128) % 256; end
        5: begin mso = mq % 2;          mq = mq / 2 + (mq % 2) * 128; end
        6: begin mso = (mq == 255);     mq = (mq + 1) % 256; end
        default: begin mso = (mq == 0); mq = (mq + 255) % 256; end
      endcase
    end
    e.q   = mq;
    e.so  = mso;
    e.par = oddOnes(mq);
    sbq.push_back(e);
  endtask

  // Monitor: consumes one expectation per edge, sampled 1 ns after it.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge Clk);
      #1;
      if (sbq.size() != 0) begin
        e   = sbq.pop_front();
        bad = 0;
        vectors++;
        if (Q !== e.q[7:0]) begin
          $display("FAIL Q: got %02h expected %02h", Q, e.q[7:0]); bad = 1;
        end
        if (notQ !== ~e.q[7:0]) begin
          $display("FAIL notQ: got %02h expected %02h", notQ, ~e.q[7:0]); bad = 1;
        end
        if (ShiftOut !== e.so[0]) begin
          $display("FAIL ShiftOut: got %b expected %b", ShiftOut, e.so[0]); bad = 1;
        end
`ifdef UNIVERSAL_REGISTER_PARITY_EN
        if (Parity !== e.par[0]) begin
          $display("FAIL Parity: got %b expected %b", Parity, e.par[0]); bad = 1;
        end
`endif
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    Rst = 1'b1; En = 1'b0; Mode = 3'b000; D = 8'h00; SerIn = 1'b0;

    // Reset regardless of enable and mode
    step(1, 1, 6, 8'h3C, 1);
    step(1, 0, 6, 8'h3C, 1);
    // Load, then disabled edges
    step(0, 1, 1, 8'hA5, 0);
    repeat (3) step(0, 0, 1, 8'hFF, 1);
    // Shifts
    step(0, 1, 1, 8'h81, 0);
    step(0, 1, 2, 8'h00, 0);
    step(0, 1, 3, 8'h00, 1);
    // Rotates
    step(0, 1, 1, 8'h81, 0);
    step(0, 1, 4, 8'h00, 1);
    step(0, 1, 5, 8'h00, 0);
    step(0, 1, 5, 8'h00, 1);
    // Count wrap both directions
    step(0, 1, 1, 8'hFE, 0);
    step(0, 1, 6, 8'h00, 0);
    step(0, 1, 6, 8'h00, 0);
    step(0, 1, 7, 8'h00, 0);
    // Reset aborts a count
    step(0, 1, 1, 8'h10, 0);
    repeat (3) step(0, 1, 6, 8'h00, 0);
    step(1, 1, 6, 8'h00, 0);
    // Parity-focused load and count
    step(0, 1, 1, 8'h07, 0);
    step(0, 1, 6, 8'h00, 0);
    // Hold mode keeps a non-zero ShiftOut
    step(0, 1, 1, 8'hFF, 0);
    step(0, 1, 6, 8'h00, 0);
    step(0, 1, 0, 8'h55, 1);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 1));

    repeat (3) @(negedge Clk);
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      miscompares++;
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
